// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// The counter helper encodes one cycle's net change in pending writes.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    function automatic logic signed [1:0] popcount_delta(input logic set, input logic clr);
        logic signed [1:0] delta;
        case ({set, clr})
            2'b10:   delta = 2'sb01;
            2'b01:   delta = 2'sb11;
            default: delta = 2'sb00;
        endcase
        return delta;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue, read and writeback signals between the pipeline and the scoreboarded
// register file. The master side is the pipeline and the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     issue_ok;
    logic [ADDR_W:0]          pending_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_busy, issue_ok, pending_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_busy, issue_ok, pending_cnt
    );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: stored value and busy bit, optional forwarding
// of the same-cycle writeback, hardwired zero register.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]   busy,
    input  logic                   wr_legal,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_busy
);

    logic is_zero_s;
    logic hit_s;

    // Select between zero register, forwarded writeback and stored state.
    always_comb begin
        is_zero_s = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_ADDR));
        hit_s     = (BYPASS != 0) && wr_legal && (wr_addr == rd_addr);
        rd_data   = '0;
        rd_busy   = 1'b0;
        if (is_zero_s) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (hit_s) begin
            rd_data = wr_data;
            rd_busy = 1'b0;
        end else begin
            rd_data = mem[rd_addr];
            rd_busy = busy[rd_addr];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy bits for in-order issue:
// issue marks a destination pending, writeback stores data and clears it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    regfile_scoreboard_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   pending_cnt_q;
    logic [ADDR_W:0]   pending_cnt_d;

    logic wr_legal_s;
    logic issue_legal_s;
    logic wr_hit_issue_s;
    logic issue_ok_s;
    logic issue_set_s;
    logic cnt_set_s;
    logic cnt_clr_s;

    // Hazard check and the set/clear events that move the pending counter.
    always_comb begin
        wr_legal_s     = bus.wr_en &&
                         !((ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(ZERO_ADDR)));
        issue_legal_s  = !((ZERO_REG != 0) && (bus.issue_addr == ADDR_W'(ZERO_ADDR)));
        wr_hit_issue_s = wr_legal_s && (bus.wr_addr == bus.issue_addr);
        issue_ok_s     = bus.issue_en && (!busy_q[bus.issue_addr] || wr_hit_issue_s);
        issue_set_s    = issue_ok_s && issue_legal_s;
        cnt_set_s      = issue_set_s && !busy_q[bus.issue_addr];
        // A writeback whose register is re-claimed in the same cycle stays pending.
        cnt_clr_s      = wr_legal_s && busy_q[bus.wr_addr] &&
                         !(issue_set_s && (bus.issue_addr == bus.wr_addr));
    end

    // Next state of storage, busy bits and counter; issue wins over writeback.
    always_comb begin
        pending_cnt_d = pending_cnt_q;
        busy_d        = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            busy_d        = '0;
            pending_cnt_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i]  = (wr_legal_s && (bus.wr_addr == ADDR_W'(i))) ? bus.wr_data : mem_q[i];
                busy_d[i] = (issue_set_s && (bus.issue_addr == ADDR_W'(i))) ? 1'b1 :
                            (wr_legal_s && (bus.wr_addr == ADDR_W'(i))) ? 1'b0 : busy_q[i];
            end
            case (popcount_delta(cnt_set_s, cnt_clr_s))
                2'sb01:  pending_cnt_d = pending_cnt_q + (ADDR_W+1)'(1);
                2'sb11:  pending_cnt_d = pending_cnt_q - (ADDR_W+1)'(1);
                default: pending_cnt_d = pending_cnt_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        mem_q         <= mem_d;
        busy_q        <= busy_d;
        pending_cnt_q <= pending_cnt_d;
    end

    assign bus.issue_ok    = issue_ok_s;
    assign bus.pending_cnt = pending_cnt_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .rd_addr  (bus.rd_addr[g*ADDR_W +: ADDR_W]),
            .mem      (mem_q),
            .busy     (busy_q),
            .wr_legal (wr_legal_s),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .rd_data  (bus.rd_data[g*DATA_W +: DATA_W]),
            .rd_busy  (bus.rd_busy[g])
        );
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the core's 32x32 register file.
- Configurable data width, depth and number of read ports, with a hardwired zero register and optional write-to-read bypass.
- Adds a per-register scoreboard: busy bits are set when an instruction that writes a register issues, and cleared at writeback. Pending writes are tracked with a counter.
- Sits between decode/issue (read ports and issue port) and writeback (write port) in the pipelined MIPS core.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value
- ZERO_REG, 1, 1 = register 0 reads 0, is never written, is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]; combinational
- rd_busy  out  NUM_RD  port i operand is pending (value not yet valid); combinational
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- issue_en  in  1  request to mark issue_addr busy (an instruction with that destination issues)
- issue_addr  in  ADDR_W  destination register of the issuing instruction
- issue_ok  out  1  issue accepted this cycle; combinational
- pending_cnt  out  ADDR_W+1  number of busy registers; registered

Behaviour:
- Reset (rst=1 at posedge):
  - All registers cleared to 0, all busy bits cleared, pending_cnt set to 0.
  - rst overrides wr_en and issue_en in the same cycle.
  - After reset, every rd_data = 0, rd_busy = 0, issue_ok = 1 when issue_en=1.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped; issue to address 0 sets no busy bit and does not change pending_cnt.
  - Reads of address 0 return 0 with rd_busy=0 regardless of bypass.
  - issue_ok=1 for address 0.
- Write (wr_en=1, address legal):
  - reg[wr_addr] <= wr_data and busy[wr_addr] <= 0 at posedge.
  - Writing a register that is not busy is legal: data updates, busy stays 0, pending_cnt unchanged.
- Issue:
  - issue_ok = issue_en & (!busy[issue_addr] | wr_hit_issue), where wr_hit_issue = wr_en & wr_addr==issue_addr & address legal.
  - This blocks WAW hazards; the requester stalls while issue_ok=0.
  - When issue_ok=1 and the address is legal, busy[issue_addr] <= 1 at posedge.
  - When issue_ok=0, no state changes from the issue port.
- Simultaneous write and accepted issue to the same address:
  - Data is written and the busy bit ends at 1, because the new producer wins.
  - pending_cnt is unchanged (-1 +1).
- pending_cnt next value = pending_cnt + set - clr:
  - set = accepted legal issue to a non-busy register.
  - clr = legal write that clears a busy bit and is not re-set by the same-cycle issue.
  - pending_cnt never exceeds 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).
- Read port i, combinational, zero latency:
  - hit = BYPASS & wr_en & wr_addr==rd_addr_i & address legal.
  - hit: rd_data_i = wr_data, rd_busy_i = 0.
  - otherwise: rd_data_i = reg[rd_addr_i], rd_busy_i = busy[rd_addr_i].
  - With BYPASS=0, a same-cycle write is visible on the next cycle only; rd_busy_i still reflects the pre-write busy bit.
- All read ports are independent; identical addresses on several ports return identical results.

Decomposition:
- Shared package regfile_pkg:
  - Default widths DATA_W/ADDR_W.
  - Constant ZERO_ADDR.
  - Function popcount_delta(set, clr) returning a signed 2-bit value.
- One natural sub-module: rf_read_port.
  - Handles the per-port mux, bypass comparison and busy lookup.
  - Instantiated NUM_RD times in a generate loop.
- Storage array, busy vector and counter stay in the top module.

Test Plan:
- Reset then read: rst=1 one cycle, read ports 0..3 at addresses 1,5,31,0 -> all rd_data=0, rd_busy=0, pending_cnt=0.
- Scoreboard: issue r5 (issue_ok=1); next cycle rd_addr0=5 -> rd_busy0=1, pending_cnt=1; re-issue r5 -> issue_ok=0; write r5=0xDEADBEEF -> next cycle rd_data0=0xDEADBEEF, rd_busy0=0, pending_cnt=0.
- Bypass: BYPASS=1, wr r7=0x12345678 while rd_addr1=7 -> same cycle rd_data1=0x12345678, rd_busy1=0. Repeat with BYPASS=0 -> old value 0, then 0x12345678 next cycle.
- Zero register: write r0=0xFFFFFFFF and issue r0 -> rd_data=0, rd_busy=0, pending_cnt unchanged, issue_ok=1.
- Simultaneous: r9 busy; same cycle wr r9=0xA5 and issue r9 -> issue_ok=1, next cycle reg=0xA5, busy[9]=1, pending_cnt unchanged.
- Reset mid-operation: issue r1,r2,r3 (pending_cnt=3), then rst with wr_en and issue_en high -> next cycle all busy 0, pending_cnt=0, registers 0.
